// File: rtl/vram_pkg.sv
// Shared types and geometry constants for the VRAM scanout arbiter.
// Optional stall statistics are enabled with the VRAM_STATS_EN macro in the top module.
package vram_pkg;

    localparam int H_RESOLUTION   = 640;
    localparam int V_RESOLUTION   = 480;
    localparam int BPP            = 4;
    localparam int DATA_W         = 16;
    localparam int ADDR_W         = 17;
    localparam int VRAM_LATENCY   = 2;
    localparam int X_W            = 13;
    localparam int Y_W            = 12;

    localparam int PPW            = DATA_W / BPP;
    localparam int PPW_LOG2       = $clog2(PPW);
    localparam int LEAD           = 2 * PPW;
    localparam int WORDS_PER_LINE = H_RESOLUTION / PPW;

    typedef logic [BPP-1:0]    pixel_t;
    typedef logic [DATA_W-1:0] vram_word_t;
    typedef logic [ADDR_W-1:0] vram_addr_t;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_DISPLAY,
        SLOT_CPU
    } slot_e;

endpackage

// File: rtl/pixel_word_shifter.sv
// Holds the next fetched VRAM word and serialises the current one into pixels,
// LSB-first, forcing black outside the displayed area.
module pixel_word_shifter
    import vram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  vram_word_t word_in,
    input  logic       active,
    input  logic       word_start,
    output pixel_t     pixel
);

    vram_word_t next_word_reg;
    vram_word_t shift_reg;
    pixel_t     pixel_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_word_reg <= '0;
            shift_reg     <= '0;
            pixel_reg     <= '0;
        end else begin
            // A load and a word_start on the same edge hand over the older word first.
            if (load) begin
                next_word_reg <= word_in;
            end
            if (active && word_start) begin
                pixel_reg <= next_word_reg[BPP-1:0];
                shift_reg <= next_word_reg >> BPP;
            end else if (active) begin
                pixel_reg <= shift_reg[BPP-1:0];
                shift_reg <= shift_reg >> BPP;
            end else begin
                pixel_reg <= '0;
            end
        end
    end

    assign pixel = pixel_reg;

endmodule

// File: rtl/vram_scanout_arbiter.sv
// Single-port VRAM sharing between fixed-slot raster reads and CPU writes.
// Define VRAM_STATS_EN to add the o_cpu_stall_cnt statistics output.
module vram_scanout_arbiter
    import vram_pkg::*;
(
    input  logic                  i_pixel_clk,
    input  logic                  i_reset_n,
    input  logic signed [X_W-1:0] i_x,
    input  logic signed [Y_W-1:0] i_y,
    input  logic [2:0]            i_hvesync,
    output logic [2:0]            o_hvesync,
    output pixel_t                o_pixel,
    input  logic                  i_cpu_valid,
    output logic                  o_cpu_ready,
    input  vram_addr_t            i_cpu_addr,
    input  vram_word_t            i_cpu_wdata,
    output vram_addr_t            o_vram_addr,
    output vram_word_t            o_vram_wdata,
    output logic                  o_vram_we,
    output logic                  o_vram_re,
    input  vram_word_t            i_vram_rdata
`ifdef VRAM_STATS_EN
    ,
    output logic [15:0]           o_cpu_stall_cnt
`endif
);

    if (VRAM_LATENCY > PPW || VRAM_LATENCY < 1) begin : g_bad_latency
        $error("VRAM_LATENCY must lie in 1..PPW");
    end
    if (PPW < 2 || (1 << PPW_LOG2) != PPW) begin : g_bad_ppw
        $error("PPW must be a power of two, at least 2");
    end

    logic                  synced_reg;
    vram_addr_t            line_base_reg;
    logic [VRAM_LATENCY:0] tag_reg;
    vram_word_t            ret_word_reg;

    logic [X_W:0] x_lead;
    logic         y_active;
    logic         x_active;
    logic         lead_in_window;
    logic         display_slot;
    logic         cpu_fire;
    logic         x_at_end;
    logic         word_start;
    logic         pix_active;
    vram_addr_t   slot_addr;
    slot_e        slot_kind;

    // x advanced by the fetch lead; sign-extended so blanking x never wraps into range.
    assign x_lead         = {i_x[X_W-1], i_x} + (X_W+1)'(LEAD);
    assign y_active       = !i_y[Y_W-1] && ($unsigned(i_y) < Y_W'(V_RESOLUTION));
    assign x_active       = !i_x[X_W-1] && ($unsigned(i_x) < X_W'(H_RESOLUTION));
    assign lead_in_window = !x_lead[X_W] && (x_lead < (X_W+1)'(H_RESOLUTION));
    assign display_slot   = synced_reg && y_active && lead_in_window
                            && (x_lead[PPW_LOG2-1:0] == '0);
    assign slot_addr      = line_base_reg + ADDR_W'(x_lead[X_W:PPW_LOG2]);
    assign o_cpu_ready    = i_reset_n && !display_slot;
    assign cpu_fire       = i_cpu_valid && o_cpu_ready;
    assign x_at_end       = ($unsigned(i_x) == X_W'(H_RESOLUTION - 1));
    assign word_start     = (i_x[PPW_LOG2-1:0] == '0);
    assign pix_active     = synced_reg && i_hvesync[2] && x_active && y_active;

    always_comb begin
        slot_kind = SLOT_IDLE;
        if (display_slot) begin
            slot_kind = SLOT_DISPLAY;
        end else if (cpu_fire) begin
            slot_kind = SLOT_CPU;
        end
    end

    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_hvesync     <= '0;
            o_vram_addr   <= '0;
            o_vram_wdata  <= '0;
            o_vram_we     <= 1'b0;
            o_vram_re     <= 1'b0;
            synced_reg    <= 1'b0;
            line_base_reg <= '0;
            tag_reg       <= '0;
            ret_word_reg  <= '0;
        end else begin
            o_hvesync <= i_hvesync;
            o_vram_we <= 1'b0;
            o_vram_re <= 1'b0;
            case (slot_kind)
                SLOT_DISPLAY: begin
                    o_vram_re   <= 1'b1;
                    o_vram_addr <= slot_addr;
                end
                SLOT_CPU: begin
                    o_vram_we    <= 1'b1;
                    o_vram_addr  <= i_cpu_addr;
                    o_vram_wdata <= i_cpu_wdata;
                end
                default: ;
            endcase

            if (i_y[Y_W-1]) begin
                synced_reg    <= 1'b1;
                line_base_reg <= '0;
            end else if (x_at_end) begin
                line_base_reg <= line_base_reg + ADDR_W'(WORDS_PER_LINE);
            end

            // Returned data is staged once so the next-word register is never
            // overwritten before the shifter has taken the word it holds.
            tag_reg <= {tag_reg[VRAM_LATENCY-1:0], o_vram_re};
            if (tag_reg[VRAM_LATENCY-1]) begin
                ret_word_reg <= i_vram_rdata;
            end
        end
    end

    pixel_word_shifter u_shifter (
        .clk        (i_pixel_clk),
        .rst_n      (i_reset_n),
        .load       (tag_reg[VRAM_LATENCY]),
        .word_in    (ret_word_reg),
        .active     (pix_active),
        .word_start (word_start),
        .pixel      (o_pixel)
    );

`ifdef VRAM_STATS_EN
    localparam int V_START = 0;

    logic [15:0] stall_cnt_reg;
    logic        at_vstart_reg;
    logic        at_vstart;

    assign at_vstart = ($unsigned(i_y) == Y_W'(V_START));

    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cnt_reg <= '0;
            at_vstart_reg <= 1'b0;
        end else begin
            at_vstart_reg <= at_vstart;
            if (at_vstart && !at_vstart_reg) begin
                stall_cnt_reg <= '0;
            end else if (i_cpu_valid && !o_cpu_ready && stall_cnt_reg != 16'hFFFF) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign o_cpu_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// Directed self-checking bench for vram_scanout_arbiter; x/y are driven directly so
// long frames can be skipped. Covers o_cpu_stall_cnt when VRAM_STATS_EN is defined.
module tb_vram_scanout_arbiter;
    import vram_pkg::*;

    logic                  clk = 1'b0;
    logic                  i_reset_n;
    logic signed [X_W-1:0] i_x;
    logic signed [Y_W-1:0] i_y;
    logic [2:0]            i_hvesync;
    logic [2:0]            o_hvesync;
    pixel_t                o_pixel;
    logic                  i_cpu_valid;
    logic                  o_cpu_ready;
    vram_addr_t            i_cpu_addr;
    vram_word_t            i_cpu_wdata;
    vram_addr_t            o_vram_addr;
    vram_word_t            o_vram_wdata;
    logic                  o_vram_we;
    logic                  o_vram_re;
    vram_word_t            i_vram_rdata;
`ifdef VRAM_STATS_EN
    logic [15:0]           o_cpu_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vram_scanout_arbiter dut (
        .i_pixel_clk  (clk),
        .i_reset_n    (i_reset_n),
        .i_x          (i_x),
        .i_y          (i_y),
        .i_hvesync    (i_hvesync),
        .o_hvesync    (o_hvesync),
        .o_pixel      (o_pixel),
        .i_cpu_valid  (i_cpu_valid),
        .o_cpu_ready  (o_cpu_ready),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_wdata  (i_cpu_wdata),
        .o_vram_addr  (o_vram_addr),
        .o_vram_wdata (o_vram_wdata),
        .o_vram_we    (o_vram_we),
        .o_vram_re    (o_vram_re),
        .i_vram_rdata (i_vram_rdata)
`ifdef VRAM_STATS_EN
        ,
        .o_cpu_stall_cnt (o_cpu_stall_cnt)
`endif
    );

    // VRAM model: word = addr * 0x1111, valid two cycles after the re pulse.
    vram_word_t rd_stage;
    always @(posedge clk) begin
        rd_stage     <= o_vram_re ? (o_vram_addr[15:0] * 16'h1111) : 16'hDEAD;
        i_vram_rdata <= rd_stage;
    end

    function automatic logic [2:0] hv(input int x, input int y);
        logic de;
        de = (x >= 0) && (x < 640) && (y >= 0) && (y < 480);
        return {de, (y < 0), (x < 0)};
    endfunction

    task automatic tick(input int x, input int y, input logic v, input int a, input int d);
        @(negedge clk);
        i_x         = X_W'(x);
        i_y         = Y_W'(y);
        i_hvesync   = hv(x, y);
        i_cpu_valid = v;
        i_cpu_addr  = vram_addr_t'(a);
        i_cpu_wdata = vram_word_t'(d);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b1;
        tick(0, 100, 1'b1, 5, 5);
        i_reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_vram_re !== 1'b0) begin errors++; $display("FAIL reset_re got %b want 0", o_vram_re); end
        checks++; if (o_vram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", o_vram_we); end
        checks++; if (o_vram_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", o_vram_addr); end
        checks++; if (o_vram_wdata !== '0) begin errors++; $display("FAIL reset_wdata got %h want 0", o_vram_wdata); end
        checks++; if (o_pixel !== '0) begin errors++; $display("FAIL reset_pixel got %h want 0", o_pixel); end
        checks++; if (o_hvesync !== 3'b000) begin errors++; $display("FAIL reset_hvesync got %b want 000", o_hvesync); end
        checks++; if (o_cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_cpu_ready); end
`ifdef VRAM_STATS_EN
        checks++; if (o_cpu_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", o_cpu_stall_cnt); end
`endif
        $display("test_reset done");
    endtask

    task automatic test_midframe_release();
        @(negedge clk);
        i_reset_n = 1'b1;
        for (int x = -8; x < 16; x++) begin
            tick(x, 100, 1'b0, 0, 0);
            #1;
            checks++; if (o_cpu_ready !== 1'b1) begin errors++; $display("FAIL unsync_ready x=%0d got %b want 1", x, o_cpu_ready); end
            after_edge();
            checks++;
            if (o_vram_re !== 1'b0 || o_pixel !== '0) begin
                errors++; $display("FAIL unsync_out x=%0d re=%b pix=%h want re=0 pix=0", x, o_vram_re, o_pixel);
            end
        end
        tick(0, -1, 1'b0, 0, 0);
        tick(-8, 0, 1'b0, 0, 0);
        #1;
        checks++; if (o_cpu_ready !== 1'b0) begin errors++; $display("FAIL first_slot_ready got %b want 0", o_cpu_ready); end
        after_edge();
        checks++;
        if (o_vram_re !== 1'b1 || o_vram_addr !== 17'd0) begin
            errors++; $display("FAIL first_read re=%b addr=%0d want re=1 addr=0", o_vram_re, o_vram_addr);
        end
        for (int x = -7; x < 640; x++) tick(x, 0, 1'b0, 0, 0);
        $display("test_midframe_release done");
    endtask

    task automatic test_cpu_active();
        int   reads  = 0;
        int   writes = 0;
        logic exp_ready;
        logic check_pix;
        logic [3:0] exp_pix;
        for (int x = -8; x < 640; x++) begin
            exp_ready = !(((x + 8) % 4 == 0) && (x < 632));
            tick(x, 1, 1'b1, 1000 + x + 8, x + 8);
            #1;
            checks++; if (o_cpu_ready !== exp_ready) begin errors++; $display("FAIL active_ready x=%0d got %b want %b", x, o_cpu_ready, exp_ready); end
            after_edge();
            checks++;
            if (o_vram_re !== !exp_ready || o_vram_we !== exp_ready) begin
                errors++; $display("FAIL active_strobe x=%0d re=%b we=%b want re=%b we=%b", x, o_vram_re, o_vram_we, !exp_ready, exp_ready);
            end else if (exp_ready) begin
                writes++;
                checks++;
                if (o_vram_addr !== vram_addr_t'(1000 + x + 8) || o_vram_wdata !== vram_word_t'(x + 8)) begin
                    errors++; $display("FAIL active_write x=%0d addr=%0d data=%0d want %0d/%0d", x, o_vram_addr, o_vram_wdata, 1000 + x + 8, x + 8);
                end
            end else begin
                reads++;
                checks++;
                if (o_vram_addr !== vram_addr_t'(160 + (x + 8) / 4)) begin
                    errors++; $display("FAIL active_read x=%0d addr=%0d want %0d", x, o_vram_addr, 160 + (x + 8) / 4);
                end
            end
            check_pix = 1'b1;
            exp_pix   = 4'h0;
            case (x)
                0:             exp_pix = 4'h0;
                1, 2, 3:       exp_pix = 4'hA;
                4:             exp_pix = 4'h1;
                5, 6, 7:       exp_pix = 4'hB;
                636:           exp_pix = 4'hF;
                637:           exp_pix = 4'h2;
                638, 639:      exp_pix = 4'h4;
                default:       check_pix = 1'b0;
            endcase
            if (check_pix) begin
                checks++; if (o_pixel !== exp_pix) begin errors++; $display("FAIL pixel x=%0d got %h want %h", x, o_pixel, exp_pix); end
            end
        end
        checks++; if (reads !== 160) begin errors++; $display("FAIL line_reads got %0d want 160", reads); end
        checks++; if (writes !== 488) begin errors++; $display("FAIL line_writes got %0d want 488", writes); end
        for (int x = -8; x <= -4; x++) tick(x, 2, 1'b1, 7, 7);
        after_edge();
`ifdef VRAM_STATS_EN
        checks++; if (o_cpu_stall_cnt !== 16'd162) begin errors++; $display("FAIL stall_line got %0d want 162", o_cpu_stall_cnt); end
`endif
        tick(-3, 2, 1'b0, 0, 0);
        $display("test_cpu_active done: reads=%0d writes=%0d", reads, writes);
    endtask

    task automatic test_vblank_cpu();
        logic v;
        for (int i = 0; i < 6; i++) begin
            v = (i != 3);
            tick(i * 7 - 100, -5, v, 17'h10000 + i * 3, 16'hC000 + i);
            #1;
            checks++; if (o_cpu_ready !== 1'b1) begin errors++; $display("FAIL vblank_ready i=%0d got %b want 1", i, o_cpu_ready); end
            after_edge();
            checks++;
            if (o_vram_we !== v || o_vram_re !== 1'b0 || o_hvesync !== hv(i * 7 - 100, -5)) begin
                errors++; $display("FAIL vblank_strobe i=%0d we=%b re=%b hv=%b want we=%b re=0 hv=%b", i, o_vram_we, o_vram_re, o_hvesync, v, hv(i * 7 - 100, -5));
            end else if (v) begin
                checks++;
                if (o_vram_addr !== vram_addr_t'(17'h10000 + i * 3) || o_vram_wdata !== vram_word_t'(16'hC000 + i)) begin
                    errors++; $display("FAIL vblank_echo i=%0d addr=%h data=%h", i, o_vram_addr, o_vram_wdata);
                end
                $display("vblank write i=%0d addr=%h data=%h", i, o_vram_addr, o_vram_wdata);
            end
        end
`ifdef VRAM_STATS_EN
        checks++; if (o_cpu_stall_cnt !== 16'd162) begin errors++; $display("FAIL stall_hold got %0d want 162", o_cpu_stall_cnt); end
`endif
        $display("test_vblank_cpu done");
    endtask

    task automatic test_line_base();
        logic exp_re;
        tick(0, -1, 1'b0, 0, 0);
        tick(639, 0, 1'b0, 0, 0);
        after_edge();
`ifdef VRAM_STATS_EN
        checks++; if (o_cpu_stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_vstart_clear got %0d want 0", o_cpu_stall_cnt); end
`endif
        for (int y = 1; y < 479; y++) tick(639, y, 1'b0, 0, 0);
        for (int x = 620; x < 640; x++) begin
            exp_re = ((x - 620) % 4 == 0) && (x <= 628);
            tick(x, 479, 1'b0, 0, 0);
            after_edge();
            checks++;
            if (o_vram_re !== exp_re) begin
                errors++; $display("FAIL last_line_re x=%0d got %b want %b", x, o_vram_re, exp_re);
            end else if (exp_re && o_vram_addr !== vram_addr_t'(76797 + (x - 620) / 4)) begin
                errors++; $display("FAIL last_line_addr x=%0d got %0d want %0d", x, o_vram_addr, 76797 + (x - 620) / 4);
            end
        end
        tick(0, -1, 1'b0, 0, 0);
        tick(-8, 0, 1'b0, 0, 0);
        after_edge();
        checks++;
        if (o_vram_re !== 1'b1 || o_vram_addr !== 17'd0) begin
            errors++; $display("FAIL next_frame re=%b addr=%0d want re=1 addr=0", o_vram_re, o_vram_addr);
        end
        $display("test_line_base done");
    endtask

    initial begin
        i_reset_n   = 1'b1;
        i_x         = '0;
        i_y         = '0;
        i_hvesync   = '0;
        i_cpu_valid = 1'b0;
        i_cpu_addr  = '0;
        i_cpu_wdata = '0;
        #2;
        test_reset();
        test_midframe_release();
        test_cpu_active();
        test_vblank_cpu();
        test_line_base();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
